// File: rtl/pp_interpolator_2.sv
// -----------------------------------------------------------------------------
// pp_interpolator_2
//
// Two-phase polyphase FIR interpolator (upsample by 2). Every accepted input
// sample produces two full-precision filtered outputs, phase 0 first and then
// phase 1. Output rescaling is left to a downstream saturate/truncate stage.
//
// Optional feature macro: PP_INTERP_BYPASS_EN
//   When defined, a 'bypass' input exists. If it is high at input accept, both
//   outputs are the input sample sign-extended (zero-order hold) while the
//   delay line keeps shifting so the filter history stays continuous.
//
// Parameters:
//   DATA_WIDTH   - signed input sample width
//   COEFF_WIDTH  - signed coefficient width
//   N_TAPS       - taps per phase (prototype length is 2*N_TAPS, N_TAPS >= 2)
//   COEFFS       - packed prototype, h[i] at [i*COEFF_WIDTH +: COEFF_WIDTH]
//   OUTPUT_WIDTH - (local) full-precision output width
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset
//   bypass        - filter bypass, sampled at accept (PP_INTERP_BYPASS_EN only)
//   src_data_in   - signed input sample
//   src_valid_in  - input sample valid
//   src_ready_out - block can accept a sample this cycle
//   dst_data_out  - signed full-precision output sample
//   dst_valid_out - output sample valid
//   dst_ready_in  - downstream accepts the output
// -----------------------------------------------------------------------------
module pp_interpolator_2 #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 5,
    parameter int N_TAPS      = 4,
    parameter logic [2*N_TAPS*COEFF_WIDTH-1:0] COEFFS =
        {5'd1, 5'd3, 5'd6, 5'd8, 5'd8, 5'd6, 5'd3, 5'd1},
    localparam int OUTPUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef PP_INTERP_BYPASS_EN
    input  logic                           bypass,
`endif
    input  logic signed [DATA_WIDTH-1:0]   src_data_in,
    input  logic                           src_valid_in,
    output logic                           src_ready_out,
    output logic signed [OUTPUT_WIDTH-1:0] dst_data_out,
    output logic                           dst_valid_out,
    input  logic                           dst_ready_in
);

    // Output sequencing states: nothing pending, phase 0 shown, phase 1 shown.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PH0  = 2'd1;
    localparam logic [1:0] ST_PH1  = 2'd2;

    localparam int HIST_DEPTH = N_TAPS - 1;

    logic [1:0] state_q;
    logic [1:0] state_d;

    // Only the N_TAPS-1 most recent past samples are kept: the oldest tap
    // value of the window would be shifted out at the very accept that could
    // use it, so it never contributes to a sum and needs no storage.
    logic signed [DATA_WIDTH-1:0] delay_q [HIST_DEPTH];

    logic signed [OUTPUT_WIDTH-1:0] dataOut_q;
    logic signed [OUTPUT_WIDTH-1:0] dataOut_d;
    logic signed [OUTPUT_WIDTH-1:0] y1Hold_q;
    logic signed [OUTPUT_WIDTH-1:0] y1Hold_d;

    logic signed [OUTPUT_WIDTH-1:0] coefExt [2*N_TAPS];
    logic signed [OUTPUT_WIDTH-1:0] xExt    [N_TAPS];
    logic signed [OUTPUT_WIDTH-1:0] phase0Sum;
    logic signed [OUTPUT_WIDTH-1:0] phase1Sum;
    logic signed [OUTPUT_WIDTH-1:0] y0Sel;
    logic signed [OUTPUT_WIDTH-1:0] y1Sel;

    logic srcAccept;

    // Coefficients are sign-extended to the output width once so that every
    // product below is a same-width signed multiply with no hidden truncation.
    for (genvar i = 0; i < 2 * N_TAPS; i++) begin : g_coef
        localparam logic [COEFF_WIDTH-1:0] C = COEFFS[i*COEFF_WIDTH +: COEFF_WIDTH];
        assign coefExt[i] = {{(OUTPUT_WIDTH - COEFF_WIDTH){C[COEFF_WIDTH-1]}}, C};
    end

    // The filter window is the incoming sample followed by the stored history.
    assign xExt[0] = {{(OUTPUT_WIDTH - DATA_WIDTH){src_data_in[DATA_WIDTH-1]}}, src_data_in};
    for (genvar k = 1; k < N_TAPS; k++) begin : g_window
        assign xExt[k] = {{(OUTPUT_WIDTH - DATA_WIDTH){delay_q[k-1][DATA_WIDTH-1]}},
                          delay_q[k-1]};
    end

    // Both polyphase branches: even prototype taps feed phase 0, odd taps
    // feed phase 1. The output width has headroom for the worst-case sum.
    always_comb begin
        phase0Sum = '0;
        phase1Sum = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            phase0Sum = phase0Sum + xExt[k] * coefExt[2*k];
            phase1Sum = phase1Sum + xExt[k] * coefExt[2*k+1];
        end
    end

`ifdef PP_INTERP_BYPASS_EN
    // Zero-order hold: repeat the sign-extended input on both phases.
    assign y0Sel = bypass ? xExt[0] : phase0Sum;
    assign y1Sel = bypass ? xExt[0] : phase1Sum;
`else
    assign y0Sel = phase0Sum;
    assign y1Sel = phase1Sum;
`endif

    // A new sample can enter when nothing is pending, or when the last
    // pending output (phase 1) is being taken this very cycle, which lets a
    // new pair follow the old one with no bubble.
    assign src_ready_out = (state_q == ST_IDLE) ||
                           ((state_q == ST_PH1) && dst_ready_in);
    assign srcAccept     = src_valid_in && src_ready_out;

    assign dst_valid_out = (state_q == ST_PH0) || (state_q == ST_PH1);
    assign dst_data_out  = dataOut_q;

    // Sequencing of the output pair. Phase 0 goes straight to the output
    // register at accept; phase 1 waits in its holding register until phase
    // 0 has been handed over. The output register only changes on accept or
    // on handshake, so data stays stable while stalled.
    always_comb begin
        state_d   = state_q;
        dataOut_d = dataOut_q;
        y1Hold_d  = y1Hold_q;
        case (state_q)
            ST_IDLE: begin
                if (srcAccept) begin
                    state_d   = ST_PH0;
                    dataOut_d = y0Sel;
                    y1Hold_d  = y1Sel;
                end
            end
            ST_PH0: begin
                if (dst_ready_in) begin
                    state_d   = ST_PH1;
                    dataOut_d = y1Hold_q;
                end
            end
            ST_PH1: begin
                if (dst_ready_in) begin
                    if (srcAccept) begin
                        state_d   = ST_PH0;
                        dataOut_d = y0Sel;
                        y1Hold_d  = y1Sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output registers and delay line. Reset discards any pending
    // pair and clears the history so the next sample starts from silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dataOut_q <= '0;
            y1Hold_q  <= '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                delay_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            dataOut_q <= dataOut_d;
            y1Hold_q  <= y1Hold_d;
            if (srcAccept) begin
                delay_q[0] <= src_data_in;
                for (int k = 1; k < HIST_DEPTH; k++) begin
                    delay_q[k] <= delay_q[k-1];
                end
            end
        end
    end

endmodule
